dual_wave_gen: RTL and testbench

Two-channel numerically controlled waveform generator that produces the 8-bit unsigned sample streams for the dual DAC output stage. Each channel has a phase accumulator and a waveform mapper (ramp, triangle, square, constant). The generator replaces the free-running ramp counter as the DAC data source. Configuration is written through a valid/ready register port into shadow registers and applied atomically to both channels by a commit write, so the two channels change frequency and phase together.

---
 rtl/dual_wave_gen.sv | 137 +++++++++++++
 tb/tb_dual_wave_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_wave_gen.sv
// Two-channel NCO waveform generator that feeds the dual DAC output stage.
// Writes land in shadow registers, and a COMMIT write moves them to both channels at once.
module dual_wave_gen #(
  parameter int PHASE_BITS = 24,
  parameter int OUT_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [2:0]            cfg_addr,
  input  logic [PHASE_BITS-1:0] cfg_data,
  output logic [OUT_BITS-1:0]   dac_a_q,
  output logic [OUT_BITS-1:0]   dac_b_q,
  output logic                  sample_valid,
  output logic                  wrap_a,
  output logic                  wrap_b
);
  localparam logic [OUT_BITS-1:0] MID = {1'b1, {(OUT_BITS-1){1'b0}}};
  localparam logic [2:0] ADDR_FREQ_A  = 3'd0;
  localparam logic [2:0] ADDR_FREQ_B  = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_DUTY    = 3'd3;
  localparam logic [2:0] ADDR_PHASE_B = 3'd4;
  localparam logic [2:0] ADDR_COMMIT  = 3'd5;

  logic [PHASE_BITS-1:0] shd_freq_a, shd_freq_b, shd_phase_b;
  logic [5:0]            shd_mode;
  logic [15:0]           shd_duty;
  logic [PHASE_BITS-1:0] freq_a, freq_b, phase_b;
  logic [5:0]            mode;
  logic [15:0]           duty;
  logic                  commit_q, resync_q;
  logic [PHASE_BITS-1:0] acc_a, acc_b;
  logic                  carry_a, carry_b;
  logic                  valid_d;
  logic                  accept, commit;
  logic [PHASE_BITS:0]   sum_a, sum_b;

  assign cfg_ready = ~commit_q;
  assign accept    = cfg_valid & cfg_ready;
  assign commit    = accept && (cfg_addr == ADDR_COMMIT);
  assign sum_a     = {1'b0, acc_a} + {1'b0, freq_a};
  assign sum_b     = {1'b0, acc_b} + {1'b0, freq_b};

  // The falling half of the triangle uses a 1 in the LSB, so the peak repeats at 254
  // and the value 255 is never produced.
  function automatic logic [OUT_BITS-1:0] wave_map(input logic [1:0] wave,
                                                  input logic [OUT_BITS-1:0] t,
                                                  input logic [OUT_BITS-1:0] lvl);
    logic [OUT_BITS-1:0] res;
    case (wave)
      2'd0:    res = t;
      2'd1:    res = t[OUT_BITS-1] ? ~{t[OUT_BITS-2:0], 1'b1} : {t[OUT_BITS-2:0], 1'b0};
      2'd2:    res = (t < lvl) ? {OUT_BITS{1'b1}} : {OUT_BITS{1'b0}};
      default: res = lvl;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      shd_freq_a  <= '0;
      shd_freq_b  <= '0;
      shd_phase_b <= '0;
      shd_mode    <= '0;
      shd_duty    <= '0;
      freq_a      <= '0;
      freq_b      <= '0;
      phase_b     <= '0;
      mode        <= '0;
      duty        <= '0;
      commit_q    <= 1'b0;
      resync_q    <= 1'b0;
    end else begin
      commit_q <= commit;
      resync_q <= commit & cfg_data[0];
      if (accept) begin
        case (cfg_addr)
          ADDR_FREQ_A:  shd_freq_a  <= cfg_data;
          ADDR_FREQ_B:  shd_freq_b  <= cfg_data;
          ADDR_MODE:    shd_mode    <= 6'(cfg_data);
          ADDR_DUTY:    shd_duty    <= 16'(cfg_data);
          ADDR_PHASE_B: shd_phase_b <= cfg_data;
          ADDR_COMMIT: begin
            freq_a  <= shd_freq_a;
            freq_b  <= shd_freq_b;
            mode    <= shd_mode;
            duty    <= shd_duty;
            phase_b <= shd_phase_b;
          end
          default: ;
        endcase
      end
    end
  end

  // Resync wins over the add and never reports a carry.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      acc_a   <= '0;
      acc_b   <= '0;
      carry_a <= 1'b0;
      carry_b <= 1'b0;
    end else if (resync_q) begin
      acc_a   <= '0;
      acc_b   <= phase_b;
      carry_a <= 1'b0;
      carry_b <= 1'b0;
    end else begin
      carry_a <= mode[4] & sum_a[PHASE_BITS];
      carry_b <= mode[5] & sum_b[PHASE_BITS];
      if (mode[4]) acc_a <= sum_a[PHASE_BITS-1:0];
      if (mode[5]) acc_b <= sum_b[PHASE_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      dac_a_q      <= '0;
      dac_b_q      <= '0;
      wrap_a       <= 1'b0;
      wrap_b       <= 1'b0;
      valid_d      <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      dac_a_q      <= mode[4] ? wave_map(mode[1:0], acc_a[PHASE_BITS-1 -: OUT_BITS],
                                         duty[OUT_BITS-1:0]) : MID;
      dac_b_q      <= mode[5] ? wave_map(mode[3:2], acc_b[PHASE_BITS-1 -: OUT_BITS],
                                         duty[2*OUT_BITS-1:OUT_BITS]) : MID;
      wrap_a       <= carry_a;
      wrap_b       <= carry_b;
      valid_d      <= 1'b1;
      sample_valid <= valid_d;
    end
  end
endmodule

// File: tb/tb_dual_wave_gen.sv
// Bench for dual_wave_gen: directed test-plan steps plus random register traffic,
// checked every cycle against an arithmetic reference model.
module tb_dual_wave_gen;
  localparam longint M = 64'd1 << 24;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [23:0] cfg_data = '0;
  logic        cfg_ready;
  logic [7:0]  dac_a_q, dac_b_q;
  logic        sample_valid, wrap_a, wrap_b;

  int total = 0;
  int bad   = 0;

  dual_wave_gen #(.PHASE_BITS(24), .OUT_BITS(8)) dut (
    .clk(clk), .nReset(nReset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .dac_a_q(dac_a_q), .dac_b_q(dac_b_q),
    .sample_valid(sample_valid), .wrap_a(wrap_a), .wrap_b(wrap_b)
  );

  always #5 clk = ~clk;

  // reference model: shadow/active configuration, phases as plain integers
  longint m_sf[2], m_af[2], m_acc[2];
  longint m_sphb, m_aphb;
  int     m_smode, m_amode, m_sduty, m_aduty;
  bit     m_carry[2];
  bit     m_resync, m_commit_last, m_v1;
  int     e_dac[2];
  bit     e_wrap[2];
  bit     e_valid;

  function automatic int exp_wave(int wv, int t, int lvl);
    case (wv)
      0:       return t;
      1:       return (t < 128) ? 2 * t : 510 - 2 * t;
      2:       return (t < lvl) ? 255 : 0;
      default: return lvl;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_sf[c] = 0; m_af[c] = 0; m_acc[c] = 0; m_carry[c] = 0;
      e_dac[c] = 0; e_wrap[c] = 0;
    end
    m_sphb = 0; m_aphb = 0; m_smode = 0; m_amode = 0; m_sduty = 0; m_aduty = 0;
    m_resync = 0; m_commit_last = 0; m_v1 = 0; e_valid = 0;
  endtask

  task automatic model_edge(input bit v, input int a, input int d);
    bit ok;
    ok = v && !m_commit_last;
    for (int c = 0; c < 2; c++) begin
      bit en;
      en = ((m_amode >> (4 + c)) & 1) != 0;
      e_dac[c]  = en ? exp_wave((m_amode >> (2 * c)) & 3, int'(m_acc[c] >> 16),
                                (m_aduty >> (8 * c)) & 255) : 128;
      e_wrap[c] = m_carry[c];
      if (m_resync) begin
        m_acc[c]   = (c == 0) ? 0 : m_aphb;
        m_carry[c] = 0;
      end else if (en) begin
        longint s;
        s = m_acc[c] + m_af[c];
        m_carry[c] = (s >= M);
        m_acc[c]   = s % M;
      end else begin
        m_carry[c] = 0;
      end
    end
    e_valid = m_v1;
    m_v1 = 1;
    m_resync      = ok && a == 5 && (d & 1) != 0;
    m_commit_last = ok && a == 5;
    if (ok) begin
      case (a)
        0: m_sf[0]  = d;
        1: m_sf[1]  = d;
        2: m_smode  = d & 63;
        3: m_sduty  = d & 16'hFFFF;
        4: m_sphb   = d;
        5: begin
          m_af[0] = m_sf[0]; m_af[1] = m_sf[1];
          m_amode = m_smode; m_aduty = m_sduty; m_aphb = m_sphb;
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cyc(input bit v, input int a, input int d);
    cfg_valid = v;
    cfg_addr  = 3'(a);
    cfg_data  = 24'(d);
    @(posedge clk);
    model_edge(v, a, d & 24'hFFFFFF);
    #1;
    chk("dac_a", dac_a_q, e_dac[0]);
    chk("dac_b", dac_b_q, e_dac[1]);
    chk("wrap_a", wrap_a, int'(e_wrap[0]));
    chk("wrap_b", wrap_b, int'(e_wrap[1]));
    chk("sample_valid", sample_valid, int'(e_valid));
    chk("cfg_ready", cfg_ready, m_commit_last ? 0 : 1);
  endtask

  task automatic wr(input int a, input int d);
    cyc(1'b1, a, d);
  endtask

  task automatic idle();
    cyc(1'b0, 0, 0);
  endtask

  logic [7:0] prev;

  initial begin
    model_reset();
    #1;
    chk("reset_dac_a", dac_a_q, 0);
    chk("reset_dac_b", dac_b_q, 0);
    chk("reset_valid", sample_valid, 0);
    chk("reset_ready", cfg_ready, 1);
    #21 nReset = 1'b1;
    idle();
    idle();
    chk("idle_dac_a", dac_a_q, 8'h80);
    chk("idle_dac_b", dac_b_q, 8'h80);
    chk("idle_valid", sample_valid, 1);

    // ramp on A
    wr(0, 32'h10000);
    wr(2, 32'h10);
    wr(5, 1);
    chk("commit_ready_low", cfg_ready, 0);
    idle();
    chk("commit_ready_back", cfg_ready, 1);
    for (int k = 0; k < 300; k++) begin
      idle();
      chk("ramp_a", dac_a_q, k % 256);
      chk("ramp_wrap", wrap_a, (k > 0 && k % 256 == 0) ? 1 : 0);
      chk("ramp_b_off", dac_b_q, 8'h80);
    end

    // shadow write does not change the step; commit without resync doubles it
    prev = dac_a_q;
    wr(0, 32'h20000);
    chk("shadow_step", 8'(dac_a_q - prev), 1);
    prev = dac_a_q;
    idle();
    chk("shadow_step2", 8'(dac_a_q - prev), 1);
    prev = dac_a_q;
    wr(5, 0);
    chk("step_at_c", 8'(dac_a_q - prev), 1);
    prev = dac_a_q;
    idle();
    chk("step_at_c1", 8'(dac_a_q - prev), 1);
    for (int k = 0; k < 4; k++) begin
      prev = dac_a_q;
      idle();
      chk("step_new", 8'(dac_a_q - prev), 2);
    end

    // both channels ramp with B half a cycle ahead
    wr(0, 32'h10000);
    wr(1, 32'h10000);
    wr(2, 32'h30);
    wr(4, 32'h800000);
    wr(5, 1);
    idle();
    for (int k = 0; k < 300; k++) begin
      idle();
      chk("phase_off", 8'(dac_b_q - dac_a_q), 128);
    end

    // square on B at 64/256 duty
    wr(4, 0);
    wr(2, 32'h38);
    wr(3, 64 << 8);
    wr(5, 1);
    idle();
    for (int k = 0; k < 512; k++) begin
      idle();
      chk("square_b", dac_b_q, (k % 256 < 64) ? 255 : 0);
    end

    // triangle on A
    wr(0, 32'h10000);
    wr(2, 32'h11);
    wr(5, 1);
    idle();
    for (int k = 0; k < 300; k++) begin
      idle();
      chk("tri_a", dac_a_q, (k % 256 < 128) ? 2 * (k % 256) : 510 - 2 * (k % 256));
    end

    // random register traffic, including commits and writes in the not-ready cycle
    for (int k = 0; k < 2000; k++)
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom() & 32'hFFFFFF));
    wr(0, 32'h0F0F0);
    wr(1, 32'h3333);
    wr(2, 32'h3F);
    wr(3, 32'h8040);
    wr(5, 1);
    for (int k = 0; k < 200; k++) idle();

    // asynchronous reset between edges
    cfg_valid = 1'b0;
    #2 nReset = 1'b0;
    #1;
    chk("arst_dac_a", dac_a_q, 0);
    chk("arst_dac_b", dac_b_q, 0);
    chk("arst_wrap_a", wrap_a, 0);
    chk("arst_wrap_b", wrap_b, 0);
    chk("arst_valid", sample_valid, 0);
    model_reset();
    @(posedge clk);
    #3 nReset = 1'b1;
    idle();
    chk("post_valid_1", sample_valid, 0);
    idle();
    chk("post_dac_a", dac_a_q, 8'h80);
    chk("post_dac_b", dac_b_q, 8'h80);
    chk("post_valid_2", sample_valid, 1);
    for (int k = 0; k < 20; k++) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
